// File: rtl/stack_viewer.sv
// Read-only viewer for the RPN calculator stack: walks a cursor down from the top of stack,
// continuously re-reads the selected entry and shows data and address on seven-segment digits.
module stack_viewer #(
    parameter int ADDR_W = 5
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [ADDR_W:0]   sp,
    input  logic              step_up,
    input  logic              step_down,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              empty,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_ADDR    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   ONE_S   = 1;
    localparam logic [ADDR_W-1:0] ONE_A   = 1;
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;
    localparam logic [6:0]        SEG_DASH  = 7'b0111111;

    state_t            state_q, state_d;
    logic              load_addr, do_capture;

    logic              up_q, down_q;
    logic              up_edge, down_edge;
    logic [ADDR_W:0]   sp_c, sp_q;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [ADDR_W-1:0] rd_addr_q, addr_d;
    logic [7:0]        data_cap_q;
    logic [ADDR_W-1:0] addr_cap_q;
    logic              empty_q, shown_q;
    logic [7:0]        addr_pad;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // A stack pointer beyond the RAM depth is treated as a full stack.
    always_comb begin
        sp_c = sp;
        if (sp > DEPTH_V) begin
            sp_c = DEPTH_V;
        end
    end

    assign up_edge   = step_up & ~up_q;
    assign down_edge = step_down & ~down_q;

    always_comb begin
        cursor_d = cursor_q;
        if (sp_c != sp_q) begin
            cursor_d = '0;
        end else if (up_edge && down_edge) begin
            cursor_d = cursor_q;
        end else if (up_edge) begin
            if (({1'b0, cursor_q} + ONE_S) < sp_c) begin
                cursor_d = cursor_q + ONE_A;
            end
        end else if (down_edge) begin
            if (cursor_q != '0) begin
                cursor_d = cursor_q - ONE_A;
            end
        end
    end

    // The address uses next-cycle cursor so a step or push seen now is read in this pass.
    always_comb begin
        addr_d = '0;
        if (sp_c != '0) begin
            addr_d = sp_c[ADDR_W-1:0] - ONE_A - cursor_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_ADDR;
        case (state_q)
            S_ADDR:    state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_ADDR;
            default:   state_d = S_ADDR;
        endcase
    end

    always_comb begin
        load_addr  = 1'b0;
        do_capture = 1'b0;
        case (state_q)
            S_ADDR:    load_addr  = 1'b1;
            S_CAPTURE: do_capture = 1'b1;
            default: begin
                load_addr  = 1'b0;
                do_capture = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            sp_q       <= '0;
            cursor_q   <= '0;
            rd_addr_q  <= '0;
            data_cap_q <= '0;
            addr_cap_q <= '0;
            empty_q    <= 1'b1;
            shown_q    <= 1'b0;
        end else begin
            up_q     <= step_up;
            down_q   <= step_down;
            sp_q     <= sp_c;
            cursor_q <= cursor_d;
            if (load_addr) begin
                rd_addr_q <= addr_d;
            end
            if (do_capture) begin
                data_cap_q <= rd_data;
                addr_cap_q <= rd_addr_q;
                empty_q    <= (sp_c == '0);
                shown_q    <= 1'b1;
            end
        end
    end

    // Nothing is shown until the first capture after reset completes.
    always_comb begin
        addr_pad = '0;
        addr_pad[ADDR_W-1:0] = addr_cap_q;
        HEX0 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        HEX4 = SEG_BLANK;
        HEX5 = SEG_BLANK;
        if (shown_q && empty_q) begin
            HEX0 = SEG_DASH;
            HEX1 = SEG_DASH;
            HEX4 = SEG_DASH;
            HEX5 = SEG_DASH;
        end else if (shown_q) begin
            HEX0 = seg7(data_cap_q[3:0]);
            HEX1 = seg7(data_cap_q[7:4]);
            HEX4 = seg7(addr_pad[3:0]);
            HEX5 = seg7(addr_pad[7:4]);
        end
    end

    assign rd_addr     = rd_addr_q;
    assign cursor      = cursor_q;
    assign empty       = empty_q;
    assign dbg_state_o = state_q;

endmodule
